// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer
// Reads the four force-sensor XADC channels (VAUX2/3/10/11) over DRP when the
// XADC signals end-of-conversion. A configuration-write requester shares the
// same DRP port.
//
// Ports:
//   CLK100MHZ, RST_BTN            clock, asynchronous active-low reset
//   eoc_in, channel_in            XADC end-of-conversion pulse and channel number
//   drp_den/dwe/daddr/di          DRP request outputs (all registered)
//   drp_do, drp_drdy              DRP response
//   cfg_req/addr/data, cfg_ack    configuration-write handshake (level req, pulse ack)
//   sample_valid/ch/data          one-cycle strobe for each completed read
//   ch0_data..ch3_data            latest value per channel
//   overrun, timeout_err          sticky error flags, cleared only by reset
module xadc_drp_sequencer #(
    parameter logic [6:0] CH0_ADDR       = 7'h12,
    parameter logic [6:0] CH1_ADDR       = 7'h13,
    parameter logic [6:0] CH2_ADDR       = 7'h1A,
    parameter logic [6:0] CH3_ADDR       = 7'h1B,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        CLK100MHZ,
    input  logic        RST_BTN,
    input  logic        eoc_in,
    input  logic [4:0]  channel_in,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    input  logic        cfg_req,
    input  logic [6:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic        cfg_ack,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic [11:0] ch0_data,
    output logic [11:0] ch1_data,
    output logic [11:0] ch2_data,
    output logic [11:0] ch3_data,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;

    localparam logic [27:0] CH_ADDRS = {CH3_ADDR, CH2_ADDR, CH1_ADDR, CH0_ADDR};

    state_t      state_reg, state_next;
    logic        slot_full_reg, slot_full_next;
    logic [6:0]  slot_addr_reg, slot_addr_next;
    logic [1:0]  slot_ch_reg, slot_ch_next;
    logic [1:0]  cur_ch_reg, cur_ch_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        last_wr_reg, last_wr_next;   // 1: last grant was the write
    logic        den_reg, den_next;
    logic        dwe_reg, dwe_next;
    logic [6:0]  daddr_reg, daddr_next;
    logic [15:0] di_reg, di_next;
    logic        ack_reg, ack_next;
    logic        sv_reg, sv_next;
    logic [1:0]  sch_reg, sch_next;
    logic [11:0] sdata_reg, sdata_next;
    logic        overrun_reg, overrun_next;
    logic        timeout_reg, timeout_next;
    logic        ch_we;

    logic [3:0]  ch_hit;
    logic [1:0]  eoc_idx;
    logic        eoc_hit;
    logic        rd_pending;
    logic [6:0]  rd_addr;
    logic [1:0]  rd_ch;
    logic        grant_rd, grant_wr;
    logic [47:0] ch_data_flat;
    logic        unused_do;

    assign unused_do = ^drp_do[3:0];   // low nibble carries no sample bits

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hit
            assign ch_hit[gi] = ({2'b00, channel_in} == CH_ADDRS[gi*7 +: 7]);
        end
    endgenerate

    always_comb begin
        eoc_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (ch_hit[i]) eoc_idx = 2'(i);
        end
    end

    assign eoc_hit = eoc_in & (|ch_hit);

    // A read may be granted on the same edge the eoc arrives, so an empty slot
    // is bypassed by the incoming request. A full slot always holds the older
    // request, which is served first.
    assign rd_pending = slot_full_reg | eoc_hit;
    assign rd_addr    = slot_full_reg ? slot_addr_reg : {2'b00, channel_in};
    assign rd_ch      = slot_full_reg ? slot_ch_reg : eoc_idx;

    always_comb begin
        state_next     = state_reg;
        slot_full_next = slot_full_reg;
        slot_addr_next = slot_addr_reg;
        slot_ch_next   = slot_ch_reg;
        cur_ch_next    = cur_ch_reg;
        cnt_next       = cnt_reg;
        last_wr_next   = last_wr_reg;
        den_next       = 1'b0;
        dwe_next       = 1'b0;
        daddr_next     = daddr_reg;
        di_next        = di_reg;
        ack_next       = 1'b0;
        sv_next        = 1'b0;
        sch_next       = sch_reg;
        sdata_next     = sdata_reg;
        overrun_next   = overrun_reg;
        timeout_next   = timeout_reg;
        ch_we          = 1'b0;
        grant_rd       = 1'b0;
        grant_wr       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rd_pending && cfg_req) begin
                    grant_rd = last_wr_reg;
                    grant_wr = ~last_wr_reg;
                end else begin
                    grant_rd = rd_pending;
                    grant_wr = cfg_req;
                end
                if (grant_rd) begin
                    den_next     = 1'b1;
                    daddr_next   = rd_addr;
                    cur_ch_next  = rd_ch;
                    cnt_next     = 8'd0;
                    last_wr_next = 1'b0;
                    state_next   = RD_WAIT;
                end else if (grant_wr) begin
                    den_next     = 1'b1;
                    dwe_next     = 1'b1;
                    daddr_next   = cfg_addr;
                    di_next      = cfg_data;
                    cnt_next     = 8'd0;
                    last_wr_next = 1'b1;
                    state_next   = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (drp_drdy) begin
                    ch_we      = 1'b1;
                    sv_next    = 1'b1;
                    sch_next   = cur_ch_reg;
                    sdata_next = drp_do[15:4];
                    state_next = IDLE;
                end else if (cnt_reg == TIMEOUT_CYCLES) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            WR_WAIT: begin
                // A timed-out write still acknowledges so the requester is released.
                if (drp_drdy) begin
                    ack_next   = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == TIMEOUT_CYCLES) begin
                    ack_next     = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Pending slot: consumed by a read grant, overwritten by a newer eoc.
        if (eoc_hit) begin
            if (!(grant_rd && !slot_full_reg)) begin
                slot_full_next = 1'b1;
                slot_addr_next = {2'b00, channel_in};
                slot_ch_next   = eoc_idx;
                if (slot_full_reg && !grant_rd) overrun_next = 1'b1;
            end
        end else if (grant_rd) begin
            slot_full_next = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_reg     <= IDLE;
            slot_full_reg <= 1'b0;
            slot_addr_reg <= 7'd0;
            slot_ch_reg   <= 2'd0;
            cur_ch_reg    <= 2'd0;
            cnt_reg       <= 8'd0;
            last_wr_reg   <= 1'b1;
            den_reg       <= 1'b0;
            dwe_reg       <= 1'b0;
            daddr_reg     <= 7'd0;
            di_reg        <= 16'd0;
            ack_reg       <= 1'b0;
            sv_reg        <= 1'b0;
            sch_reg       <= 2'd0;
            sdata_reg     <= 12'd0;
            overrun_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            slot_full_reg <= slot_full_next;
            slot_addr_reg <= slot_addr_next;
            slot_ch_reg   <= slot_ch_next;
            cur_ch_reg    <= cur_ch_next;
            cnt_reg       <= cnt_next;
            last_wr_reg   <= last_wr_next;
            den_reg       <= den_next;
            dwe_reg       <= dwe_next;
            daddr_reg     <= daddr_next;
            di_reg        <= di_next;
            ack_reg       <= ack_next;
            sv_reg        <= sv_next;
            sch_reg       <= sch_next;
            sdata_reg     <= sdata_next;
            overrun_reg   <= overrun_next;
            timeout_reg   <= timeout_next;
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic [11:0] data_reg;
            always_ff @(posedge CLK100MHZ or negedge RST_BTN) begin
                if (!RST_BTN) begin
                    data_reg <= 12'd0;
                end else if (ch_we && (cur_ch_reg == 2'(gi))) begin
                    data_reg <= drp_do[15:4];
                end
            end
            assign ch_data_flat[gi*12 +: 12] = data_reg;
        end
    endgenerate

    assign drp_den      = den_reg;
    assign drp_dwe      = dwe_reg;
    assign drp_daddr    = daddr_reg;
    assign drp_di       = di_reg;
    assign cfg_ack      = ack_reg;
    assign sample_valid = sv_reg;
    assign sample_ch    = sch_reg;
    assign sample_data  = sdata_reg;
    assign ch0_data     = ch_data_flat[11:0];
    assign ch1_data     = ch_data_flat[23:12];
    assign ch2_data     = ch_data_flat[35:24];
    assign ch3_data     = ch_data_flat[47:36];
    assign overrun      = overrun_reg;
    assign timeout_err  = timeout_reg;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench for xadc_drp_sequencer: table-driven reads, randomized
// read/write/ignored-eoc traffic against a channel-map model, and hand-written
// sequences for overrun, arbitration, timeout and reset corner cases.
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        eoc_in;
    logic [4:0]  channel_in;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic        cfg_req;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_ack;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [11:0] sample_data;
    logic [11:0] ch0_data, ch1_data, ch2_data, ch3_data;
    logic        overrun, timeout_err;

    always #5 clk = ~clk;

    xadc_drp_sequencer dut (
        .CLK100MHZ   (clk),
        .RST_BTN     (rst_n),
        .eoc_in      (eoc_in),
        .channel_in  (channel_in),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .cfg_req     (cfg_req),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_ack     (cfg_ack),
        .sample_valid(sample_valid),
        .sample_ch   (sample_ch),
        .sample_data (sample_data),
        .ch0_data    (ch0_data),
        .ch1_data    (ch1_data),
        .ch2_data    (ch2_data),
        .ch3_data    (ch3_data),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_ch [4];
    logic [4:0]  addr_tab [4];

    typedef struct {
        logic [4:0]  ch;
        logic [15:0] do_val;
        int          lat;
        logic [6:0]  exp_addr;
        logic [1:0]  exp_idx;
        logic [11:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ch_port(input int i);
        case (i)
            0:       return ch0_data;
            1:       return ch1_data;
            2:       return ch2_data;
            default: return ch3_data;
        endcase
    endfunction

    // Model: channel index is the position of the channel number in the map.
    function automatic int find_idx(input logic [4:0] c);
        for (int i = 0; i < 4; i++) if (addr_tab[i] == c) return i;
        return -1;
    endfunction

    task automatic check_chans(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s ch%0d_data", tag, i), ch_port(i), exp_ch[i]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " den"}, drp_den, 0);
        chk({tag, " dwe"}, drp_dwe, 0);
        chk({tag, " daddr"}, drp_daddr, 0);
        chk({tag, " di"}, drp_di, 0);
        chk({tag, " cfg_ack"}, cfg_ack, 0);
        chk({tag, " sample_valid"}, sample_valid, 0);
        chk({tag, " sample_ch"}, sample_ch, 0);
        chk({tag, " sample_data"}, sample_data, 0);
        chk({tag, " overrun"}, overrun, 0);
        chk({tag, " timeout_err"}, timeout_err, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s ch%0d", tag, i), ch_port(i), 0);
    endtask

    task automatic expect_den(input logic [6:0] addr, input logic we, input string tag);
        chk({tag, " den"}, drp_den, 1);
        chk({tag, " dwe"}, drp_dwe, we);
        chk({tag, " daddr"}, drp_daddr, addr);
    endtask

    task automatic pulse_eoc(input logic [4:0] c);
        eoc_in = 1'b1;
        channel_in = c;
        step();
        eoc_in = 1'b0;
    endtask

    // Called in the den cycle (or later); returns in the cycle after drdy.
    task automatic complete_read(input logic [15:0] data, input int lat, input int idx,
                                 input logic [11:0] exp_data, input bit co_en,
                                 input logic [4:0] co_ch);
        for (int k = 1; k < lat; k++) begin
            step();
            chk("den while busy", drp_den, 0);
        end
        drp_drdy = 1'b1;
        drp_do = data;
        if (co_en) begin
            eoc_in = 1'b1;
            channel_in = co_ch;
        end
        step();
        drp_drdy = 1'b0;
        eoc_in = 1'b0;
        exp_ch[idx] = exp_data;
        chk("sample_valid", sample_valid, 1);
        chk("sample_ch", sample_ch, idx);
        chk("sample_data", sample_data, exp_data);
        check_chans("rd");
        $display("txn read ch%0d data=%03h lat=%0d", idx, exp_data, lat);
    endtask

    // Called in the write den cycle; returns in the cycle after cfg_ack.
    task automatic complete_write(input int lat);
        for (int k = 1; k < lat; k++) begin
            step();
            chk("den while wr busy", drp_den, 0);
        end
        drp_drdy = 1'b1;
        step();
        drp_drdy = 1'b0;
        chk("cfg_ack", cfg_ack, 1);
        chk("no sample on write", sample_valid, 0);
        cfg_req = 1'b0;
        step();
        chk("cfg_ack single", cfg_ack, 0);
        $display("txn write addr=%02h lat=%0d", cfg_addr, lat);
    endtask

    task automatic do_read(input logic [4:0] c, input logic [15:0] data, input int lat);
        int idx;
        idx = find_idx(c);
        pulse_eoc(c);
        expect_den({2'b00, c}, 1'b0, "rd");
        complete_read(data, lat, idx, data[15:4], 1'b0, 5'd0);
        step();
        chk("sample_valid once", sample_valid, 0);
        chk("idle den", drp_den, 0);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [15:0] d, input int lat);
        cfg_req = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        expect_den(a, 1'b1, "wr");
        chk("wr di", drp_di, d);
        complete_write(lat);
        chk("idle after wr", drp_den, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) exp_ch[i] = 12'd0;
    endtask

    initial begin
        addr_tab[0] = 5'h12; addr_tab[1] = 5'h13; addr_tab[2] = 5'h1A; addr_tab[3] = 5'h1B;
        vecs[0] = '{5'h12, 16'hABC0, 3, 7'h12, 2'd0, 12'hABC};
        vecs[1] = '{5'h13, 16'h1235, 1, 7'h13, 2'd1, 12'h123};
        vecs[2] = '{5'h1A, 16'hFFFF, 2, 7'h1A, 2'd2, 12'hFFF};
        vecs[3] = '{5'h1B, 16'h000F, 4, 7'h1B, 2'd3, 12'h000};
        vecs[4] = '{5'h1B, 16'h8010, 1, 7'h1B, 2'd3, 12'h801};
        vecs[5] = '{5'h12, 16'h5A5A, 6, 7'h12, 2'd0, 12'h5A5};

        rst_n = 1'b0; eoc_in = 1'b0; channel_in = 5'd0; drp_do = 16'd0; drp_drdy = 1'b0;
        cfg_req = 1'b0; cfg_addr = 7'd0; cfg_data = 16'd0;
        for (int i = 0; i < 4; i++) exp_ch[i] = 12'd0;
        step();
        step();
        check_all_zero("in reset");
        rst_n = 1'b1;
        step();
        check_all_zero("after reset");

        // Table-driven single reads.
        for (int v = 0; v < 6; v++) begin
            pulse_eoc(vecs[v].ch);
            expect_den(vecs[v].exp_addr, 1'b0, $sformatf("vec%0d", v));
            complete_read(vecs[v].do_val, vecs[v].lat, int'(vecs[v].exp_idx),
                          vecs[v].exp_data, 1'b0, 5'd0);
            step();
            chk("vec sample once", sample_valid, 0);
            chk("vec den once", drp_den, 0);
        end

        // eoc on the same edge as drdy: slot loads, read issues one cycle later.
        pulse_eoc(5'h13);
        expect_den(7'h13, 1'b0, "co1");
        complete_read(16'h6540, 2, 1, 12'h654, 1'b1, 5'h1B);
        step();
        expect_den(7'h1B, 1'b0, "co2");
        complete_read(16'h9870, 3, 3, 12'h987, 1'b0, 5'd0);
        step();
        chk("co idle", drp_den, 0);

        // Pending slot and overrun.
        pulse_eoc(5'h1B);
        expect_den(7'h1B, 1'b0, "ov1");
        pulse_eoc(5'h13);
        chk("overrun after one pending", overrun, 0);
        complete_read(16'h4440, 2, 3, 12'h444, 1'b0, 5'd0);
        step();
        expect_den(7'h13, 1'b0, "ov2");
        complete_read(16'h3330, 1, 1, 12'h333, 1'b0, 5'd0);
        step();
        chk("ov idle", drp_den, 0);
        chk("overrun still clear", overrun, 0);
        pulse_eoc(5'h12);
        expect_den(7'h12, 1'b0, "ov3");
        pulse_eoc(5'h13);
        chk("overrun pending13", overrun, 0);
        pulse_eoc(5'h1A);
        chk("overrun set", overrun, 1);
        complete_read(16'h2220, 1, 0, 12'h222, 1'b0, 5'd0);
        step();
        expect_den(7'h1A, 1'b0, "ov4");
        complete_read(16'h1110, 2, 2, 12'h111, 1'b0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("no read of replaced 13", drp_den, 0);
        end

        // Randomized traffic against the channel-map model.
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [4:0] c;
            r = $urandom_range(0, 5);
            if (r < 4) begin
                do_read(addr_tab[r], 16'($urandom), $urandom_range(1, 6));
            end else if (r == 4) begin
                c = 5'($urandom_range(0, 31));
                while (find_idx(c) >= 0) c = 5'($urandom_range(0, 31));
                pulse_eoc(c);
                chk("ignored eoc den", drp_den, 0);
                step();
                chk("ignored eoc den2", drp_den, 0);
                $display("txn ignored eoc ch=%02h", c);
            end else begin
                do_write(7'($urandom), 16'($urandom), $urandom_range(1, 6));
            end
        end

        // Read timeout.
        begin
            int n_sv;
            n_sv = 0;
            pulse_eoc(5'h12);
            expect_den(7'h12, 1'b0, "to rd");
            for (int k = 1; k <= 255; k++) begin
                step();
                if (sample_valid) n_sv++;
            end
            chk("timeout not yet", timeout_err, 0);
            step();
            chk("timeout_err", timeout_err, 1);
            chk("timeout no sample", sample_valid, 0);
            chk("sample count in timeout", n_sv, 0);
            check_chans("timeout");
            $display("txn read timeout");
        end
        do_read(5'h13, 16'hC3C0, 2);
        chk("timeout sticky", timeout_err, 1);

        // Write timeout still acknowledges.
        cfg_req = 1'b1; cfg_addr = 7'h55; cfg_data = 16'h0F0F;
        step();
        expect_den(7'h55, 1'b1, "to wr");
        for (int k = 1; k <= 255; k++) step();
        chk("wr ack not yet", cfg_ack, 0);
        step();
        chk("wr timeout ack", cfg_ack, 1);
        cfg_req = 1'b0;
        step();
        chk("wr timeout ack single", cfg_ack, 0);
        chk("wr timeout idle", drp_den, 0);
        $display("txn write timeout");

        // Non-matching channel.
        pulse_eoc(5'h03);
        for (int k = 0; k < 3; k++) begin
            chk("ch03 den", drp_den, 0);
            step();
        end

        // Reset during RD_WAIT; late drdy must be ignored.
        pulse_eoc(5'h1B);
        expect_den(7'h1B, 1'b0, "rst rd");
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) exp_ch[i] = 12'd0;
        drp_drdy = 1'b1;
        drp_do = 16'hFFF0;
        step();
        drp_drdy = 1'b0;
        chk("late drdy sample", sample_valid, 0);
        chk("late drdy ch3", ch3_data, 0);
        step();
        chk("late drdy den", drp_den, 0);
        $display("txn reset during read");

        // Tie after reset: read first, then write.
        cfg_req = 1'b1; cfg_addr = 7'h41; cfg_data = 16'h2000;
        pulse_eoc(5'h12);
        expect_den(7'h12, 1'b0, "tie1 rd");
        complete_read(16'h7770, 3, 0, 12'h777, 1'b0, 5'd0);
        step();
        expect_den(7'h41, 1'b1, "tie1 wr");
        chk("tie1 di", drp_di, 16'h2000);
        complete_write(2);
        chk("tie1 idle", drp_den, 0);

        // After a read grant, the next tie goes to the write.
        do_read(5'h13, 16'h0120, 1);
        cfg_req = 1'b1; cfg_addr = 7'h42; cfg_data = 16'h1234;
        pulse_eoc(5'h1A);
        expect_den(7'h42, 1'b1, "tie2 wr");
        chk("tie2 di", drp_di, 16'h1234);
        complete_write(1);
        expect_den(7'h1A, 1'b0, "tie2 rd");
        complete_read(16'hBEE0, 2, 2, 12'hBEE, 1'b0, 5'd0);
        step();
        chk("tie2 idle", drp_den, 0);
        chk("tie2 overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
